// File: rtl/rv32i_csr_trap_ctrl.sv
// Machine-mode CSR file and trap/mret redirect controller for the single-stage RV32I core.
// Optional CSR_COUNTERS_EN adds the 64-bit mcycle/minstret counters.
module rv32i_csr_trap_ctrl #(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] MTVEC_RESET   = 32'h0,
  parameter logic [31:0] HART_ID       = 32'h0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ce,
  input  logic                     i_stall,
  input  logic                     i_csr_en,
  input  logic [2:0]               i_csr_op,
  input  logic [11:0]              i_csr_addr,
  input  logic [31:0]              i_csr_wdata,
  output logic [31:0]              o_csr_rdata,
  output logic                     o_csr_illegal,
  input  logic                     i_is_inst_illegal,
  input  logic                     i_is_ecall,
  input  logic                     i_is_ebreak,
  input  logic                     i_is_mret,
  input  logic [31:0]              i_pc,
  input  logic                     i_ext_irq,
  input  logic                     i_sw_irq,
  input  logic                     i_timer_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] i_local_irq,
  output logic [31:0]              o_trap_address,
  output logic [31:0]              o_return_address,
  output logic                     o_go_to_trap_q,
  output logic                     o_return_from_trap_q
);
  localparam logic [31:0] LOCAL_MASK = 32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
  localparam logic [31:0] MIE_MASK   = LOCAL_MASK | 32'h0000_0888;

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [31:0] mip, pend, csr_val, wval, mtvec_base, trap_target;
  logic        csr_impl, csr_ro, write_intent, csr_we;
  logic        act, irq_take, exc_take, illegal_any, trap, mret_take, is_ebreak_exc;
  logic [4:0]  irq_cause, exc_cause, trap_cause;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q, mcycle_inc, minstret_inc;
`endif

  always_comb begin
    mip     = 32'h0;
    mip[11] = i_ext_irq;
    mip[3]  = i_sw_irq;
    mip[7]  = i_timer_irq;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip[16+i] = i_local_irq[i];
  end

  always_comb begin
    csr_val  = 32'h0;
    csr_impl = 1'b1;
    csr_ro   = 1'b0;
    case (i_csr_addr)
      12'h300: csr_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      12'h301: csr_val = 32'h4000_0100;
      12'h304: csr_val = mie_q;
      12'h305: csr_val = mtvec_q;
      12'h340: csr_val = mscratch_q;
      12'h341: csr_val = mepc_q;
      12'h342: csr_val = mcause_q;
      12'h343: csr_val = mtval_q;
      12'h344: begin csr_val = mip; csr_ro = 1'b1; end
      12'hF11, 12'hF12, 12'hF13: csr_ro = 1'b1;
      12'hF14: begin csr_val = HART_ID; csr_ro = 1'b1; end
`ifdef CSR_COUNTERS_EN
      12'hB00: csr_val = mcycle_q[31:0];
      12'hB80: csr_val = mcycle_q[63:32];
      12'hB02: csr_val = minstret_q[31:0];
      12'hB82: csr_val = minstret_q[63:32];
`endif
      default: csr_impl = 1'b0;
    endcase
  end

  // RS/RC with a zero mask are pure reads and must not trip read-only checks
  assign write_intent  = (i_csr_op[1:0] == 2'b01) ||
                         ((i_csr_op[1:0] != 2'b00) && (i_csr_wdata != 32'h0));
  assign o_csr_illegal = i_csr_en && (!csr_impl || (csr_ro && write_intent));
  assign o_csr_rdata   = i_csr_en ? csr_val : 32'h0;

  always_comb begin
    case (i_csr_op[1:0])
      2'b01:   wval = i_csr_wdata;
      2'b10:   wval = csr_val | i_csr_wdata;
      2'b11:   wval = csr_val & ~i_csr_wdata;
      default: wval = csr_val;
    endcase
  end

  always_comb begin
    pend      = mie_q & mip;
    irq_take  = 1'b0;
    irq_cause = 5'd0;
    if (mstatus_mie) begin
      if (pend[11]) begin irq_take = 1'b1; irq_cause = 5'd11; end
      else if (pend[3]) begin irq_take = 1'b1; irq_cause = 5'd3; end
      else if (pend[7]) begin irq_take = 1'b1; irq_cause = 5'd7; end
      else begin
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
          if (pend[16+i]) begin irq_take = 1'b1; irq_cause = 5'(16 + i); end
        end
      end
    end
  end

  assign illegal_any   = i_is_inst_illegal || o_csr_illegal;
  assign exc_take      = illegal_any || i_is_ecall || i_is_ebreak;
  assign exc_cause     = illegal_any ? 5'd2 : (i_is_ecall ? 5'd11 : 5'd3);
  assign is_ebreak_exc = !irq_take && !illegal_any && !i_is_ecall && i_is_ebreak;

  // The cycle after a redirect carries a flushed instruction and never commits
  assign act        = i_ce && !i_stall && !o_go_to_trap_q && !o_return_from_trap_q;
  assign trap       = act && (irq_take || exc_take);
  assign trap_cause = irq_take ? irq_cause : exc_cause;
  assign mret_take  = act && i_is_mret && !trap;
  assign csr_we     = act && i_csr_en && !o_csr_illegal && write_intent && !trap;

  assign mtvec_base  = {mtvec_q[31:2], 2'b00};
  assign trap_target = (mtvec_q[0] && irq_take) ? mtvec_base + {25'b0, trap_cause, 2'b00}
                                                : mtvec_base;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mstatus_mie          <= 1'b0;
      mstatus_mpie         <= 1'b0;
      mie_q                <= 32'h0;
      mtvec_q              <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
      mscratch_q           <= 32'h0;
      mepc_q               <= 32'h0;
      mcause_q             <= 32'h0;
      mtval_q              <= 32'h0;
      o_trap_address       <= 32'h0;
      o_return_address     <= 32'h0;
      o_go_to_trap_q       <= 1'b0;
      o_return_from_trap_q <= 1'b0;
    end else begin
      o_go_to_trap_q       <= trap;
      o_return_from_trap_q <= mret_take;
      if (csr_we) begin
        case (i_csr_addr)
          12'h300: begin mstatus_mie <= wval[3]; mstatus_mpie <= wval[7]; end
          12'h304: mie_q      <= wval & MIE_MASK;
          12'h305: mtvec_q    <= {wval[31:2], 1'b0, wval[0]};
          12'h340: mscratch_q <= wval;
          12'h341: mepc_q     <= {wval[31:2], 2'b00};
          12'h342: mcause_q   <= wval;
          12'h343: mtval_q    <= wval;
          default: ;
        endcase
      end
      if (trap) begin
        mepc_q         <= {i_pc[31:2], 2'b00};
        mcause_q       <= {irq_take, 26'b0, trap_cause};
        mtval_q        <= is_ebreak_exc ? i_pc : 32'h0;
        mstatus_mpie   <= mstatus_mie;
        mstatus_mie    <= 1'b0;
        o_trap_address <= trap_target;
      end
      if (mret_take) begin
        mstatus_mie      <= mstatus_mpie;
        mstatus_mpie     <= 1'b1;
        o_return_address <= mepc_q;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  assign mcycle_inc   = mcycle_q + 64'd1;
  assign minstret_inc = minstret_q + {63'b0, (act && !trap)};

  // A write to one half replaces only that half's increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q[31:0]    <= (csr_we && i_csr_addr == 12'hB00) ? wval : mcycle_inc[31:0];
      mcycle_q[63:32]   <= (csr_we && i_csr_addr == 12'hB80) ? wval : mcycle_inc[63:32];
      minstret_q[31:0]  <= (csr_we && i_csr_addr == 12'hB02) ? wval : minstret_inc[31:0];
      minstret_q[63:32] <= (csr_we && i_csr_addr == 12'hB82) ? wval : minstret_inc[63:32];
    end
  end
`endif
endmodule
